// File: rtl/ca_row_engine_if.sv
// Row-write bus of the cellular-automaton engine: control pulses in, image RAM row writes out.
// Write-only; the RAM accepts a row every cycle, so there is no backpressure.
interface ca_row_engine_if #(
  parameter int WIDTH = 80
);
  logic             start;
  logic             frame_tick;
  logic             wr_en;
  logic [6:0]       wr_row;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic [15:0]      gen_count;

  modport master (
    input  start, frame_tick,
    output wr_en, wr_row, wr_data, busy, gen_count
  );

  modport slave (
    output start, frame_tick,
    input  wr_en, wr_row, wr_data, busy, gen_count
  );
endinterface

// File: rtl/ca_row_engine.sv
// Elementary 1-D CA: fills ROWS image rows one generation per cycle, then scrolls one generation per frame_tick; CA_WRAP_EN selects toroidal edges.
// start -> first write 1 cycle later, ROWS back-to-back writes; no backpressure, pulses outside IDLE/HOLD are dropped.
module ca_row_engine #(
  parameter int               WIDTH = 80,
  parameter int               ROWS  = 60,
  parameter logic [7:0]       RULE  = 8'd30,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1) << (WIDTH / 2)
) (
  input logic           clk,
  input logic           rst,
  ca_row_engine_if.master bus
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cur, cur_nxt, cur_gen;
  logic [WIDTH-1:0] top_next, top_nxt;
  logic [6:0]       row, row_nxt;
  logic [15:0]      gen, gen_nxt;
  logic             fill_d;

  logic             wr_en_q;
  logic [6:0]       wr_row_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             busy_q;

  // ext[i +: 3] = {left, centre, right} of cell i, with edge cells padded.
  logic [WIDTH+1:0] ext;
`ifdef CA_WRAP_EN
  assign ext = {cur[0], cur, cur[WIDTH-1]};
`else
  assign ext = {1'b0, cur, 1'b0};
`endif

  always_comb begin
    cur_gen = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cur_gen[i] = RULE[ext[i +: 3]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)        state_nxt = FILL;
      FILL:    if (row == LAST_ROW)  state_nxt = HOLD;
      HOLD:    if (bus.frame_tick)   state_nxt = FILL;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_nxt = cur;
    top_nxt = top_next;
    row_nxt = row;
    gen_nxt = gen;
    case (state)
      IDLE: begin
        cur_nxt = SEED;
        row_nxt = '0;
      end
      FILL: begin
        cur_nxt = cur_gen;
        if (row == '0) top_nxt = cur_gen;
        row_nxt = (row == LAST_ROW) ? 7'd0 : row + 7'd1;
      end
      HOLD: begin
        // Restarting from the old row-1 generation scrolls the screen up by one.
        if (bus.frame_tick) begin
          cur_nxt = top_next;
          gen_nxt = gen + 16'd1;
          row_nxt = '0;
        end
      end
      default: begin
        cur_nxt = SEED;
        row_nxt = '0;
      end
    endcase
    fill_d = (state_nxt == FILL);
  end

  // Outputs are loaded with the values the FILL cycle will present, keeping them registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= SEED;
      top_next  <= '0;
      row       <= '0;
      gen       <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      cur       <= cur_nxt;
      top_next  <= top_nxt;
      row       <= row_nxt;
      gen       <= gen_nxt;
      wr_en_q   <= fill_d;
      busy_q    <= fill_d;
      wr_row_q  <= fill_d ? row_nxt : 7'd0;
      wr_data_q <= fill_d ? cur_nxt : '0;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_row    = wr_row_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.gen_count = gen;

endmodule
